// File: rtl/merlin_mem_arb_pkg.sv
// Shared types for the merlin32i instruction/data memory arbiter.
// A request's source tag travels through the in-order tag FIFO.
package merlin_mem_arb_pkg;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_tag_e;

  function automatic src_tag_e other_src(input src_tag_e src);
    return (src == SRC_I) ? SRC_D : SRC_I;
  endfunction

endpackage

// File: rtl/merlin_tag_fifo.sv
// Small synchronous FIFO with registered pointers and occupancy count.
// Push is ignored when full and pop is ignored when empty.
module merlin_tag_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = push_ok ? next_ptr(wptr_q) : wptr_q;
    rptr_d  = pop_ok ? next_ptr(rptr_q) : rptr_q;
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/merlin_mem_arb.sv
// Round-robin 2:1 arbiter sharing one memory target between the merlin32i
// instruction and data ports; responses are routed back in request order.
module merlin_mem_arb
  import merlin_mem_arb_pkg::*;
#(
  parameter int unsigned C_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        ireqready_o,
  input  logic        ireqvalid_i,
  input  logic [31:0] ireqaddr_i,
  input  logic        irspready_i,
  output logic        irspvalid_o,
  output logic        irsprerr_o,
  output logic [31:0] irspdata_o,
  output logic        dreqready_o,
  input  logic        dreqvalid_i,
  input  logic [31:0] dreqaddr_i,
  input  logic [3:0]  dreqbe_i,
  input  logic [31:0] dreqdata_i,
  input  logic        drspready_i,
  output logic        drspvalid_o,
  output logic        drsperr_o,
  output logic [31:0] drspdata_o,
  input  logic        treqready_i,
  output logic        treqvalid_o,
  output logic [31:0] treqaddr_o,
  output logic [3:0]  treqbe_o,
  output logic [31:0] treqdata_o,
  output logic        trspready_o,
  input  logic        trspvalid_i,
  input  logic        trsperr_i,
  input  logic [31:0] trspdata_i
);

  logic     lock_q, lock_d;
  src_tag_e lock_src_q, lock_src_d;
  src_tag_e last_grant_q, last_grant_d;

  logic     grant_valid;
  src_tag_e grant_src;
  logic     accept;

  logic     fifo_full, fifo_empty;
  logic     push_tag;
  logic     head_raw;
  src_tag_e head;
  logic     rsp_sel_i, rsp_sel_d;
  logic     rsp_pop;

  // Request side: a stalled grant stays locked so target fields remain stable.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = SRC_I;
    if (!reset_i && !fifo_full) begin
      if (lock_q) begin
        grant_valid = 1'b1;
        grant_src   = lock_src_q;
      end else if (ireqvalid_i && dreqvalid_i) begin
        grant_valid = 1'b1;
        grant_src   = other_src(last_grant_q);
      end else if (ireqvalid_i) begin
        grant_valid = 1'b1;
        grant_src   = SRC_I;
      end else if (dreqvalid_i) begin
        grant_valid = 1'b1;
        grant_src   = SRC_D;
      end
    end
  end

  always_comb begin
    treqvalid_o = 1'b0;
    treqaddr_o  = '0;
    treqbe_o    = '0;
    treqdata_o  = '0;
    ireqready_o = 1'b0;
    dreqready_o = 1'b0;
    if (grant_valid) begin
      if (grant_src == SRC_D) begin
        treqvalid_o = dreqvalid_i;
        treqaddr_o  = dreqaddr_i;
        treqbe_o    = dreqbe_i;
        treqdata_o  = dreqdata_i;
        dreqready_o = treqready_i;
      end else begin
        treqvalid_o = ireqvalid_i;
        treqaddr_o  = ireqaddr_i;
        ireqready_o = treqready_i;
      end
    end
  end

  assign accept = treqvalid_o & treqready_i;

  always_comb begin
    last_grant_d = last_grant_q;
    lock_d       = lock_q;
    lock_src_d   = lock_src_q;
    if (accept) begin
      last_grant_d = grant_src;
      lock_d       = 1'b0;
    end else if (treqvalid_o) begin
      lock_d     = 1'b1;
      lock_src_d = grant_src;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_q       <= 1'b0;
      lock_src_q   <= SRC_I;
      last_grant_q <= SRC_I;
    end else begin
      lock_q       <= lock_d;
      lock_src_q   <= lock_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign push_tag = grant_src;

  merlin_tag_fifo #(
    .Width (1),
    .Depth (C_DEPTH)
  ) u_tag_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (accept),
    .push_data_i (push_tag),
    .pop_i       (rsp_pop),
    .head_o      (head_raw),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Response side: with no tag outstanding, target responses are refused.
  assign head      = src_tag_e'(head_raw);
  assign rsp_sel_i = ~reset_i & ~fifo_empty & (head == SRC_I);
  assign rsp_sel_d = ~reset_i & ~fifo_empty & (head == SRC_D);

  assign trspready_o = (rsp_sel_i & irspready_i) | (rsp_sel_d & drspready_i);
  assign rsp_pop     = trspvalid_i & trspready_o;

  assign irspvalid_o = trspvalid_i & rsp_sel_i;
  assign irsprerr_o  = trsperr_i & rsp_sel_i;
  assign irspdata_o  = rsp_sel_i ? trspdata_i : '0;

  assign drspvalid_o = trspvalid_i & rsp_sel_d;
  assign drsperr_o   = trsperr_i & rsp_sel_d;
  assign drspdata_o  = rsp_sel_d ? trspdata_i : '0;

endmodule

// File: doc/merlin_mem_arb.md
Name: merlin_mem_arb

Overview:
Two-to-one arbiter that lets the merlin32i instruction port and data port share a single memory target port, such as a boot ROM or unified SRAM.
- Requests are arbitrated round-robin.
- The source of each accepted request is recorded in an in-order tag FIFO, and target responses are routed back to the matching requester.
- Sits between the core and a single-ported memory.

Parameters:
C_DEPTH, 4, maximum accepted-but-unanswered requests (tag FIFO depth, >=1)

Ports:
clk_i  in  1  clock, all state on rising edge
reset_i  in  1  synchronous active-high reset
ireqready_o  out  1  instruction request accepted
ireqvalid_i  in  1  instruction request valid
ireqaddr_i  in  32  instruction fetch address
irspready_i  in  1  core can take instruction response
irspvalid_o  out  1  instruction response valid
irsprerr_o  out  1  instruction read error
irspdata_o  out  32  instruction word
dreqready_o  out  1  data request accepted
dreqvalid_i  in  1  data request valid
dreqaddr_i  in  32  data address
dreqbe_i  in  4  byte enables; nonzero=write, zero=read
dreqdata_i  in  32  write data
drspready_i  in  1  core can take data response
drspvalid_o  out  1  data response valid
drsperr_o  out  1  data read/write error
drspdata_o  out  32  read data
treqready_i  in  1  target accepts request
treqvalid_o  out  1  target request valid
treqaddr_o  out  32  muxed address
treqbe_o  out  4  muxed byte enables (0 for instruction)
treqdata_o  out  32  muxed write data (0 for instruction)
trspready_o  out  1  routed response ready
trspvalid_i  in  1  target response valid, in request order
trsperr_i  in  1  target response error
trspdata_i  in  32  target response data

Behaviour:
Reset:
- reset_i high clears the FIFO (count=0), clears lock, and sets last_grant=I.
- While reset_i is high, all valid/ready outputs are 0; data outputs are don't-care.
- Reset mid-transfer drops in-flight tags, so responses arriving later are ignored (trspready_o=0).

Grant (combinational, zero latency):
- With lock clear and FIFO not full:
  - only one requester valid: grant it;
  - both valid: grant the one not equal to last_grant.
- FIFO full (count==C_DEPTH): treqvalid_o=0 and both req readies=0, even if a pop occurs in the same cycle.

Handshake:
- treqvalid_o = granted requester's valid; the granted req ready = treqready_i; the other req ready = 0.
- Accept = treqvalid_o & treqready_i. On accept: push the source tag (0=I, 1=D), set last_grant, clear lock.
- treqvalid_o & !treqready_i sets lock. The grant is held until accept, so target-side request fields stay stable while valid.

Response routing:
- FIFO head tag selects the destination.
- irspvalid_o = trspvalid_i & (head==I); drspvalid_o = trspvalid_i & (head==D).
- trspready_o = head requester's rspready; trspready_o=0 when the FIFO is empty.
- Pop on trspvalid_i & trspready_o.
- Error and data pass through unregistered; the non-selected port's data is 0.

Counters:
- count width is $clog2(C_DEPTH+1).
- Same-cycle push and pop leaves count unchanged; pointers wrap modulo C_DEPTH.

Decomposition:
- Package merlin_mem_arb_pkg holds the tag typedef (enum logic {SRC_I, SRC_D}).
- Sub-module merlin_tag_fifo: a synchronous FIFO with parameterised width and depth, providing push/pop, full/empty, and head outputs.

Test Plan:
1. Reset, then ireqvalid_i=1 @0x100 with treqready_i=1 → treqvalid_o=1, treqaddr_o=0x100, treqbe_o=0, ireqready_o=1 in the same cycle; response data 0x13 → irspvalid_o=1, irspdata_o=0x13.
2. I and D both valid every cycle, target always ready → grants D, I, D, I (D wins the first tie); responses route to the matching ports in order.
3. D write @0x200 with be=0xF and data 0xDEADBEEF, treqready_i=0 for 3 cycles while I is also raised → target fields stay unchanged for 3 cycles; I granted only after D is accepted.
4. C_DEPTH=4, 4 accepts with no responses → 5th request stalls (treqvalid_o=0); one response pops the FIFO → the next cycle accepts.
5. Response with trsperr_i=1 at a D head and drspready_i=0 for 2 cycles → drspvalid_o held, trspready_o=0; the pop happens only when drspready_i=1, with drsperr_o=1.
6. reset_i asserted with 2 tags outstanding → count=0; a following trspvalid_i sees trspready_o=0 and no irspvalid_o or drspvalid_o.
